// File: rtl/fp_result_byte_sequencer_if.sv
// Bus between the FPU result source / push-button and the byte sequencer.
// The sequencer takes the slave side; whoever drives the result word and button takes master.
interface fp_result_byte_sequencer_if;
    logic        result_valid;
    logic [31:0] result;
    logic        next_btn;
    logic [7:0]  char;
    logic [1:0]  byte_idx;
    logic        loaded;

    modport master (output result_valid, result, next_btn, input char, byte_idx, loaded);
    modport slave  (input result_valid, result, next_btn, output char, byte_idx, loaded);
endinterface

// File: rtl/fp_result_byte_sequencer.sv
// Captures a 32-bit FPU result and steps it out MSB-byte first on a debounced button press.
// Define FP_SEQ_AUTO_SCROLL_EN to also advance automatically after DWELL_CYCLES per byte.
module fp_result_byte_sequencer #(
    parameter int DEB_CYCLES   = 1_000_000,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input logic                       clk,
    input logic                       rst,
    fp_result_byte_sequencer_if.slave bus
);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {EMPTY, SHOW} state_t;

    state_t            state;
    logic [31:0]       held;
    logic [1:0]        idx;
    logic [7:0]        char_q;
    logic              loaded_q;
    logic              sync0;
    logic              sync1;
    logic              btn_level;
    logic [DEB_W-1:0]  deb_cnt;
    logic              press;
    logic              advance;
    logic [1:0]        next_idx;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd3:    b = word[31:24];
            2'd2:    b = word[23:16];
            2'd1:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // A level change is accepted only after DEB_CYCLES consecutive differing samples;
    // press fires once, on the accepted rising level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            btn_level <= 1'b0;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            sync0 <= bus.next_btn;
            sync1 <= sync0;
            press <= 1'b0;
            if (sync1 == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                btn_level <= ~btn_level;
                press     <= ~btn_level;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

`ifdef FP_SEQ_AUTO_SCROLL_EN
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_tc;

    assign dwell_tc = (state == SHOW) && (dwell_cnt == DWELL_LAST);
    assign advance  = press || dwell_tc;

    // Dwell restarts on every capture and every advance, whichever source caused it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else if (bus.result_valid || state != SHOW || advance) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
    end
`else
    assign advance = press;

    // Nothing is built from DWELL_CYCLES here; it stays so both builds share one instantiation.
    if (DWELL_CYCLES < 1) begin : g_dwell_unused
    end
`endif

    assign next_idx = idx - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            held     <= '0;
            idx      <= 2'd3;
            char_q   <= 8'h00;
            loaded_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (bus.result_valid) begin
                        state    <= SHOW;
                        held     <= bus.result;
                        idx      <= 2'd3;
                        char_q   <= bus.result[31:24];
                        loaded_q <= 1'b1;
                    end
                end
                SHOW: begin
                    // A new result wins over an advance landing on the same edge.
                    if (bus.result_valid) begin
                        held   <= bus.result;
                        idx    <= 2'd3;
                        char_q <= bus.result[31:24];
                    end else if (advance) begin
                        idx    <= next_idx;
                        char_q <= pick_byte(held, next_idx);
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.char     = char_q;
    assign bus.byte_idx = idx;
    assign bus.loaded   = loaded_q;
endmodule

// File: tb/tb_fp_result_byte_sequencer.sv
// Directed bench for fp_result_byte_sequencer with DEB_CYCLES=4, DWELL_CYCLES=8.
// Auto-scroll checks run when FP_SEQ_AUTO_SCROLL_EN is defined, button checks otherwise.
module tb_fp_result_byte_sequencer;
    logic clk;
    logic rst;
    int   checkCount;
    int   failCount;

    fp_result_byte_sequencer_if bus ();

    fp_result_byte_sequencer #(
        .DEB_CYCLES  (4),
        .DWELL_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] c, input logic [1:0] i, input logic l);
        checkOutput({tag, ".char"}, {24'h0, bus.char}, {24'h0, c});
        checkOutput({tag, ".byte_idx"}, {30'h0, bus.byte_idx}, {30'h0, i});
        checkOutput({tag, ".loaded"}, {31'h0, bus.loaded}, {31'h0, l});
    endtask

    // Drive one cycle of inputs, then sample point is 1 ns after the edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic btn);
        bus.result_valid = valid;
        bus.result       = word;
        bus.next_btn     = btn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    // Long enough to be accepted as a press, then released long enough to settle low.
    task automatic pressButton();
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        bus.result_valid = 1'b0;
        bus.result       = 32'h0;
        bus.next_btn     = 1'b0;
        idle(2);
        checkAll("reset", 8'h00, 2'd3, 1'b0);
        rst = 1'b0;
        idle(20);
        checkAll("idle", 8'h00, 2'd3, 1'b0);
        pressButton();
        checkAll("empty_press", 8'h00, 2'd3, 1'b0);

`ifdef FP_SEQ_AUTO_SCROLL_EN
        begin
            logic [7:0] steps [4];
            steps[0] = 8'h20; steps[1] = 8'h00; steps[2] = 8'h00; steps[3] = 8'hC1;
            applyStimulus(1'b1, 32'hC1200000, 1'b0);
            checkAll("auto_load", 8'hC1, 2'd3, 1'b1);
            for (int s = 0; s < 4; s++) begin
                idle(7);
                checkOutput("auto_hold", {24'h0, bus.char}, {24'h0, (s == 0) ? 8'hC1 : steps[s-1]});
                idle(1);
                checkAll("auto_step", steps[s], 2'd3 - 2'(s + 1), 1'b1);
            end
            for (int c = 1; c <= 16; c++) begin
                applyStimulus(1'b0, 32'h0, (c <= 8) ? 1'b1 : 1'b0);
                if (c == 6)  checkAll("auto_press_pre", 8'hC1, 2'd3, 1'b1);
                if (c == 7)  checkAll("auto_press", 8'h20, 2'd2, 1'b1);
                if (c == 8)  checkAll("auto_restart", 8'h20, 2'd2, 1'b1);
                if (c == 14) checkAll("auto_restart_hold", 8'h20, 2'd2, 1'b1);
                if (c == 15) checkAll("auto_after_restart", 8'h00, 2'd1, 1'b1);
            end
        end
`else
        applyStimulus(1'b1, 32'h3FC00000, 1'b0);
        checkAll("load_3fc", 8'h3F, 2'd3, 1'b1);
        pressButton();
        checkAll("step1", 8'hC0, 2'd2, 1'b1);
        pressButton();
        checkAll("step2", 8'h00, 2'd1, 1'b1);
        pressButton();
        checkAll("step3", 8'h00, 2'd0, 1'b1);
        pressButton();
        checkAll("wrap", 8'h3F, 2'd3, 1'b1);

        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
        checkAll("load_dead", 8'hDE, 2'd3, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
        idle(10);
        checkAll("glitch", 8'hDE, 2'd3, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            if (c == 6)  checkAll("hold_pre", 8'hDE, 2'd3, 1'b1);
            if (c == 7)  checkAll("hold_adv", 8'hAD, 2'd2, 1'b1);
            if (c == 30) checkAll("hold_once", 8'hAD, 2'd2, 1'b1);
        end
        idle(10);
        checkAll("release", 8'hAD, 2'd2, 1'b1);
        pressButton();
        checkAll("to_idx1", 8'hBE, 2'd1, 1'b1);

        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h12345678, 1'b1);
        checkAll("collide", 8'h12, 2'd3, 1'b1);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
        idle(10);
        checkAll("collide_after", 8'h12, 2'd3, 1'b1);

        pressButton();
        checkAll("s34", 8'h34, 2'd2, 1'b1);
        pressButton();
        checkAll("s56", 8'h56, 2'd1, 1'b1);
        pressButton();
        checkAll("s78", 8'h78, 2'd0, 1'b1);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkAll("midreset", 8'h00, 2'd3, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
        checkAll("reload", 8'hCA, 2'd3, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
        idle(12);
        checkAll("short_press", 8'hCA, 2'd3, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end
endmodule
